angle_sequencer: RTL and testbench



---
 rtl/angle_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_angle_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_sequencer.sv
// rtl/angle_sequencer.sv - slew-limited four-joint servo angle sequencer
// Define ANGLE_SEQ_PARALLEL_EN to step all joints together; default moves one joint at a time.
module angle_sequencer #(
  parameter int STEP_DIV      = 50000,
  parameter int SETTLE_CYCLES = 250000,
  parameter int HOME_ANGLE    = 90,
  parameter int MAX_ANGLE     = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_angle1,
  input  logic [7:0] cmd_angle2,
  input  logic [7:0] cmd_angle3,
  input  logic [7:0] cmd_angle4,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic       busy,
  output logic       done
);

  localparam int CNT_MAX = (STEP_DIV > SETTLE_CYCLES) ? STEP_DIV : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [7:0]    HOME        = 8'(HOME_ANGLE);
  localparam logic [7:0]    MAX         = 8'(MAX_ANGLE);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, MOVE, SETTLE, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    ang [4];
  logic [7:0]    tgt [4];
  logic [7:0]    ang_step [4];
  logic [3:0]    differ;
  logic [CW-1:0] cnt;
  logic [1:0]    joint;
  logic [1:0]    sel_idx;
  logic          sel_any;
  logic          load_phase;
  logic          tick;
  logic          step_done;

  assign tick = (cnt == STEP_LAST);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      differ[i] = (ang[i] != tgt[i]);
      if (ang[i] < tgt[i])
        ang_step[i] = ang[i] + 8'd1;
      else if (ang[i] > tgt[i])
        ang_step[i] = ang[i] - 8'd1;
      else
        ang_step[i] = ang[i];
    end
  end

  // Lowest differing joint; after a settle only joints above the active one qualify.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (differ[i] && (state == LOAD || 2'(i) > joint)) begin
        sel_any = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

`ifdef ANGLE_SEQ_PARALLEL_EN
  always_comb begin
    step_done = tick;
    for (int i = 0; i < 4; i++)
      if (ang_step[i] != tgt[i])
        step_done = 1'b0;
  end
`else
  assign step_done = tick && (ang_step[joint] == tgt[joint]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = LOAD;
      LOAD:    if (load_phase) state_nxt = sel_any ? MOVE : DONE;
      MOVE:    if (step_done) state_nxt = SETTLE;
      SETTLE: begin
        if (cnt == CNT_ONE) begin
`ifdef ANGLE_SEQ_PARALLEL_EN
          state_nxt = DONE;
`else
          state_nxt = sel_any ? MOVE : DONE;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    cmd_ready = (state == IDLE);
    done      = (state == DONE);
  end

  // LOAD spans two cycles: clamp into the target registers, then pick the joint from them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ang[i] <= HOME;
        tgt[i] <= HOME;
      end
      cnt        <= '0;
      joint      <= 2'd0;
      load_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            tgt[0] <= cmd_angle1;
            tgt[1] <= cmd_angle2;
            tgt[2] <= cmd_angle3;
            tgt[3] <= cmd_angle4;
          end
          cnt        <= '0;
          load_phase <= 1'b0;
        end
        LOAD: begin
          if (!load_phase) begin
            for (int i = 0; i < 4; i++)
              if (tgt[i] > MAX) tgt[i] <= MAX;
            load_phase <= 1'b1;
          end else begin
            load_phase <= 1'b0;
            joint      <= sel_idx;
            cnt        <= '0;
          end
        end
        MOVE: begin
          if (tick) begin
`ifdef ANGLE_SEQ_PARALLEL_EN
            for (int i = 0; i < 4; i++)
              ang[i] <= ang_step[i];
`else
            ang[joint] <= ang_step[joint];
`endif
            cnt <= step_done ? SETTLE_LOAD : '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            joint <= sel_idx;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign angle1 = ang[0];
  assign angle2 = ang[1];
  assign angle3 = ang[2];
  assign angle4 = ang[3];

endmodule

// File: tb/tb_angle_sequencer.sv
// tb/tb_angle_sequencer.sv - scoreboard bench for angle_sequencer
// Expected angle snapshots are queued per command and matched as outputs change.
module tb_angle_sequencer;

  localparam int SD = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_angle1 = 8'd0, cmd_angle2 = 8'd0, cmd_angle3 = 8'd0, cmd_angle4 = 8'd0;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int              k;
    logic [3:0][7:0] a;
    logic            d;
  } ev_t;

  ev_t             q[$];
  logic [3:0][7:0] m;

  always #5 clk = ~clk;

  angle_sequencer #(.STEP_DIV(SD), .SETTLE_CYCLES(SC), .HOME_ANGLE(90), .MAX_ANGLE(180)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_angle1(cmd_angle1), .cmd_angle2(cmd_angle2), .cmd_angle3(cmd_angle3), .cmd_angle4(cmd_angle4),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .busy(busy), .done(done)
  );

  function automatic logic [3:0][7:0] obs();
    return {angle4, angle3, angle2, angle1};
  endfunction

  function automatic logic [7:0] clampv(input logic [7:0] v);
    return (v > 8'd180) ? 8'd180 : v;
  endfunction

  function automatic logic [7:0] stepv(input logic [7:0] cur, input logic [7:0] t);
    if (cur < t) return cur + 8'd1;
    if (cur > t) return cur - 8'd1;
    return cur;
  endfunction

  // Push snapshots (k = edges after acceptance) for the command into the scoreboard.
  task automatic build_expected(input logic [3:0][7:0] t);
    logic [3:0][7:0] c;
    int k;
    ev_t e;
    k = 2;
    for (int i = 0; i < 4; i++) c[i] = clampv(t[i]);
`ifdef ANGLE_SEQ_PARALLEL_EN
    begin
      int mx;
      mx = 0;
      for (int i = 0; i < 4; i++) begin
        int d;
        d = (m[i] > c[i]) ? int'(m[i]) - int'(c[i]) : int'(c[i]) - int'(m[i]);
        if (d > mx) mx = d;
      end
      for (int n = 1; n <= mx; n++) begin
        for (int i = 0; i < 4; i++) m[i] = stepv(m[i], c[i]);
        e.k = k + SD * n; e.a = m; e.d = 1'b0;
        q.push_back(e);
      end
      if (mx > 0) k = k + SD * mx + SC;
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (m[i] != c[i]) begin
        while (m[i] != c[i]) begin
          m[i] = stepv(m[i], c[i]);
          k = k + SD;
          e.k = k; e.a = m; e.d = 1'b0;
          q.push_back(e);
        end
        k = k + SC;
      end
    end
`endif
    e.k = k; e.a = m; e.d = 1'b1;
    q.push_back(e);
  endtask

  task automatic run_cmd(input string name, input logic [7:0] a1, a2, a3, a4);
    logic [3:0][7:0] prev;
    ev_t  e;
    int   budget;
    bit   seen_done;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_before got=%b want=1", name, cmd_ready);
    end
    cmd_angle1 = a1; cmd_angle2 = a2; cmd_angle3 = a3; cmd_angle4 = a4;
    cmd_valid = 1'b1;
    build_expected({a4, a3, a2, a1});
    budget = q[$].k + 10;
    prev = obs();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL %s busy_after_accept got=%b/%b want=1/0", name, busy, cmd_ready);
    end
    seen_done = 1'b0;
    for (int k = 1; k <= budget && !seen_done; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs() !== prev || done === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL %s unexpected_change k=%0d angles=%h done=%b", name, k, obs(), done);
        end else begin
          e = q.pop_front();
          if (e.k != k || obs() !== e.a || done !== e.d) begin
            bad++;
            $display("FAIL %s event k=%0d angles=%h done=%b want k=%0d angles=%h done=%b",
                     name, k, obs(), done, e.k, e.a, e.d);
          end
        end
        if (done === 1'b1) seen_done = 1'b1;
        prev = obs();
      end
    end
    total++;
    if (!seen_done || q.size() != 0) begin
      bad++; $display("FAIL %s timeout done_seen=%b pending=%0d want 1/0", name, seen_done, q.size());
      q.delete();
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after_done done=%b ready=%b busy=%b want 0/1/0", name, done, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_angle1 = 8'd10; cmd_angle2 = 8'd20; cmd_angle3 = 8'd30; cmd_angle4 = 8'd40;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    m = {4{8'd90}};
    total++;
    if (obs() !== {4{8'd90}} || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset angles=%h ready=%b busy=%b done=%b want 5a5a5a5a/1/0/0",
                      obs(), cmd_ready, busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (obs() !== {4{8'd90}} || busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle angles=%h busy=%b want 5a5a5a5a/0", obs(), busy);
    end
  endtask

  task automatic test_busy_and_reset();
    @(negedge clk);
    cmd_angle1 = 8'd95; cmd_angle2 = 8'd90; cmd_angle3 = 8'd90; cmd_angle4 = 8'd90;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_angle1 = 8'd50; cmd_angle2 = 8'd50; cmd_angle3 = 8'd50; cmd_angle4 = 8'd50;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0) begin
        bad++; $display("FAIL busy_ready k=%0d got=%b want=0", k, cmd_ready);
      end
    end
    total++;
    if (obs() !== {8'd90, 8'd90, 8'd90, 8'd92}) begin
      bad++; $display("FAIL busy_progress angles=%h want 5a5a5a5c", obs());
    end
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m = {4{8'd90}};
    total++;
    if (obs() !== {4{8'd90}} || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midmove_reset angles=%h ready=%b busy=%b done=%b want 5a5a5a5a/1/0/0",
                      obs(), cmd_ready, busy, done);
    end
  endtask

  task automatic test_single();
    run_cmd("single_up", 8'd100, 8'd90, 8'd90, 8'd90);
  endtask

  task automatic test_two_joints();
    run_cmd("two_joints", 8'd80, 8'd95, 8'd90, 8'd90);
  endtask

  task automatic test_clamp();
    run_cmd("clamp", 8'd200, 8'd90, 8'd90, 8'd90);
    total++;
    if (angle1 !== 8'd180) begin
      bad++; $display("FAIL clamp_final got=%0d want=180", angle1);
    end
  endtask

  task automatic test_no_motion();
    run_cmd("no_motion", 8'd90, 8'd90, 8'd90, 8'd90);
  endtask

  task automatic test_pair();
    run_cmd("pair", 8'd94, 8'd92, 8'd90, 8'd90);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 8'd88, 8'd90, 8'd93, 8'd87);
    run_cmd("b2b_b", 8'd90, 8'd91, 8'd90, 8'd90);
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_two_joints();
    test_clamp();
    test_reset();
    test_no_motion();
    test_busy_and_reset();
    test_pair();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
